// File: rtl/in_port_pkg.sv
// Shared types and constants for the IN-port slice: FSM state encoding and IN-mode values.
package in_port_pkg;

    // Width of the switch bus and of the captured operand.
    localparam int unsigned DataW = 16;

    // IN-instruction mode bit, qualified only while inreq is high.
    localparam logic InmodeBtn = 1'b0;  // wait for a debounced ENTER press
    localparam logic InmodeImm = 1'b1;  // sample the switches immediately

    // Capture FSM. DONE lasts exactly one cycle and is the only state driving invalid.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/in_port_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, debounced level and a
// one-cycle pulse on each debounced 0->1 transition. Releases produce no pulse.
module in_port_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic press_edge
);

    // Terminal count: the level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             btn_s_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             edge_q, edge_d;

    // Two-stage synchroniser for the asynchronous raw button.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            btn_s_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            btn_s_q <= sync1_q;
        end
    end

    // Count consecutive samples that disagree with the debounced level; any agreeing
    // sample restarts the count, so bounces shorter than DEBOUNCE_CYCLES are rejected.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        edge_d  = 1'b0;
        if (btn_s_q != level_q) begin
            if (cnt_q == CntMax) begin
                level_d = ~level_q;
                cnt_d   = '0;
                edge_d  = ~level_q;  // only a 0->1 flip is a press
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Debounce state and registered press pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
            edge_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
        end
    end

    assign press_edge = edge_q;

endmodule

// File: rtl/in_port.sv
// IN-instruction operand source: captures the DIP switches either immediately or on a
// debounced ENTER press, signalling completion with a one-cycle invalid pulse.
module in_port
    import in_port_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] sw,
    input  logic        btn_enter,
    input  logic        inreq,
    input  logic        inmode,
    output logic [15:0] inval,
    output logic        invalid,
    output logic        inwait
);

    logic [DataW-1:0] sw_sync1_q;
    logic [DataW-1:0] sw_s_q;
    logic [DataW-1:0] inval_q, inval_d;
    state_e           state_q, state_d;
    logic             press_edge;

    // ENTER button conditioning.
    in_port_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce_enter (
        .clock      (clock),
        .reset      (reset),
        .btn        (btn_enter),
        .press_edge (press_edge)
    );

    // Two-stage synchroniser for the switch bus. Switches are quasi-static, so a
    // per-bit synchroniser is adequate; a skewed bit only delays that bit by a cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_sync1_q <= '0;
            sw_s_q     <= '0;
        end else begin
            sw_sync1_q <= sw;
            sw_s_q     <= sw_sync1_q;
        end
    end

    // Next-state and capture logic. Requests outside IDLE and presses outside WAIT are
    // dropped; a press coinciding with the request that enters WAIT is therefore lost.
    always_comb begin
        state_d = state_q;
        inval_d = inval_q;
        case (state_q)
            StIdle: begin
                if (inreq) begin
                    if (inmode == InmodeImm) begin
                        state_d = StDone;
                        inval_d = sw_s_q;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (press_edge) begin
                    state_d = StDone;
                    inval_d = sw_s_q;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and captured-value registers; inval is cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            inval_q <= '0;
        end else begin
            state_q <= state_d;
            inval_q <= inval_d;
        end
    end

    // Outputs decode straight from the state register so reset clears them immediately.
    assign inval   = inval_q;
    assign invalid = (state_q == StDone);
    assign inwait  = (state_q == StWait);

endmodule

// File: tb/tb_in_port.sv
// Directed bench for in_port with DEBOUNCE_CYCLES=4.
module tb_in_port;

    logic        clock;
    logic        reset;
    logic [15:0] sw;
    logic        btn_enter;
    logic        inreq;
    logic        inmode;
    logic [15:0] inval;
    logic        invalid;
    logic        inwait;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pulse  = 0;

    in_port #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .sw        (sw),
        .btn_enter (btn_enter),
        .inreq     (inreq),
        .inmode    (inmode),
        .inval     (inval),
        .invalid   (invalid),
        .inwait    (inwait)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count cycles in which invalid is high.
    always @(posedge clock) begin
        if (invalid === 1'b1) n_pulse++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Advance until invalid is seen or the budget runs out; n = cycles taken (-1 if none).
    task automatic wait_valid(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (invalid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic request(input logic mode);
        inreq  = 1'b1;
        inmode = mode;
        tick();
        inreq  = 1'b0;
        inmode = 1'b0;
    endtask

    int lat;
    int p0;

    initial begin
        reset     = 1'b1;
        sw        = 16'h0;
        btn_enter = 1'b0;
        inreq     = 1'b0;
        inmode    = 1'b0;
        #2;
        check_eq("rst_inval", {16'h0, inval}, 32'h0);
        check_eq("rst_invalid", {31'h0, invalid}, 32'h0);
        check_eq("rst_inwait", {31'h0, inwait}, 32'h0);
        tick(2);
        reset = 1'b0;
        tick(2);

        // 1. Immediate capture, one-cycle latency.
        sw = 16'hBEEF;
        tick(3);
        p0 = n_pulse;
        request(1'b1);
        check_eq("imm_invalid", {31'h0, invalid}, 32'h1);
        check_eq("imm_inval", {16'h0, inval}, 32'hBEEF);
        check_eq("imm_inwait", {31'h0, inwait}, 32'h0);
        tick();
        check_eq("imm_pulse_end", {31'h0, invalid}, 32'h0);
        check_eq("imm_pulses", n_pulse - p0, 1);

        // 2. Clean press in button mode.
        sw = 16'h1234;
        tick(3);
        p0 = n_pulse;
        request(1'b0);
        check_eq("btn_inwait", {31'h0, inwait}, 32'h1);
        check_eq("btn_no_early", {31'h0, invalid}, 32'h0);
        btn_enter = 1'b1;
        wait_valid(20, lat);
        check_eq("btn_latency_ok", {31'h0, (lat >= 6 && lat <= 8)}, 32'h1);
        check_eq("btn_inval", {16'h0, inval}, 32'h1234);
        check_eq("btn_inwait_clr", {31'h0, inwait}, 32'h0);
        tick(4);
        btn_enter = 1'b0;
        tick(10);
        check_eq("btn_pulses", n_pulse - p0, 1);

        // 3. Bounce rejection.
        sw = 16'h5A5A;
        tick(3);
        p0 = n_pulse;
        request(1'b0);
        btn_enter = 1'b1; tick();
        btn_enter = 1'b0; tick();
        btn_enter = 1'b1; tick();
        btn_enter = 1'b0; tick();
        check_eq("bnc_no_pulse", n_pulse - p0, 0);
        btn_enter = 1'b1;
        wait_valid(20, lat);
        check_eq("bnc_latency_ok", {31'h0, (lat >= 6 && lat <= 8)}, 32'h1);
        check_eq("bnc_inval", {16'h0, inval}, 32'h5A5A);
        tick(4);
        btn_enter = 1'b0;
        tick(10);
        check_eq("bnc_pulses", n_pulse - p0, 1);

        // 4. Button already held when WAIT is entered.
        btn_enter = 1'b1;
        tick(10);
        p0 = n_pulse;
        request(1'b0);
        tick(12);
        check_eq("held_no_pulse", n_pulse - p0, 0);
        check_eq("held_inwait", {31'h0, inwait}, 32'h1);
        btn_enter = 1'b0;
        tick(8);
        sw = 16'h00FF;
        tick(3);
        btn_enter = 1'b1;
        wait_valid(20, lat);
        check_eq("held_seen", {31'h0, (lat > 0)}, 32'h1);
        check_eq("held_inval", {16'h0, inval}, 32'h00FF);
        tick(4);
        btn_enter = 1'b0;
        tick(10);
        check_eq("held_pulses", n_pulse - p0, 1);

        // 5. Requests during WAIT and DONE are ignored; switches change during WAIT.
        sw = 16'hA1A1;
        tick(3);
        p0 = n_pulse;
        request(1'b0);
        sw = 16'hC3C3;
        tick(3);
        request(1'b1);
        check_eq("ign_wait_inwait", {31'h0, inwait}, 32'h1);
        check_eq("ign_wait_invalid", {31'h0, invalid}, 32'h0);
        btn_enter = 1'b1;
        wait_valid(20, lat);
        check_eq("ign_seen", {31'h0, (lat > 0)}, 32'h1);
        check_eq("ign_inval", {16'h0, inval}, 32'hC3C3);
        request(1'b1);
        check_eq("ign_done_invalid", {31'h0, invalid}, 32'h0);
        check_eq("ign_done_inwait", {31'h0, inwait}, 32'h0);
        tick(3);
        btn_enter = 1'b0;
        tick(10);
        check_eq("ign_pulses", n_pulse - p0, 1);
        check_eq("ign_inval_hold", {16'h0, inval}, 32'hC3C3);

        // 6. Asynchronous reset while waiting.
        sw = 16'hBEEF;
        tick(3);
        request(1'b1);
        check_eq("rw_inval", {16'h0, inval}, 32'hBEEF);
        tick();
        request(1'b0);
        check_eq("rw_inwait", {31'h0, inwait}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("rw_rst_inval", {16'h0, inval}, 32'h0);
        check_eq("rw_rst_inwait", {31'h0, inwait}, 32'h0);
        check_eq("rw_rst_invalid", {31'h0, invalid}, 32'h0);
        tick(2);
        reset = 1'b0;
        p0 = n_pulse;
        tick(2);
        btn_enter = 1'b1;
        tick(15);
        btn_enter = 1'b0;
        tick(8);
        check_eq("rw_no_pulse", n_pulse - p0, 0);
        check_eq("rw_inval_zero", {16'h0, inval}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
